// File: rtl/comp_1.sv
// comp_1: registered magnitude comparator producing one-hot lt/gt/eq flags.
// Signed compare is done by flipping the sign bits and comparing unsigned.
module comp_1 #(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             lt,
    output logic             gt,
    output logic             eq
);
    localparam logic [WIDTH-1:0] FLIP = WIDTH'(SIGNED) << (WIDTH - 1);
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_lt;
    logic             w_gt;
    logic             r_lt;
    logic             r_gt;
    logic             r_eq;
    assign w_a  = A ^ FLIP;
    assign w_b  = B ^ FLIP;
    assign w_lt = w_a < w_b;
    assign w_gt = w_a > w_b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lt <= 1'b0;
            r_gt <= 1'b0;
            r_eq <= 1'b1;
        end else begin
            r_lt <= w_lt;
            r_gt <= w_gt;
            r_eq <= ~(w_lt | w_gt);
        end
    end
    assign lt = r_lt;
    assign gt = r_gt;
    assign eq = r_eq;
endmodule

// File: tb/tb_comp_1.sv
// tb_comp_1: scoreboard bench for comp_1 in four width/signedness configurations.
module tb_comp_1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a1, b1, a1s, b1s;
    logic [7:0] a8, b8, a8s, b8s;
    logic       lt1, gt1, eq1, lt1s, gt1s, eq1s, lt8, gt8, eq8, lt8s, gt8s, eq8s;

    comp_1 #(.WIDTH(1), .SIGNED(1'b0)) u_w1u (.clk(clk), .rst_n(rst_n), .A(a1),  .B(b1),  .lt(lt1),  .gt(gt1),  .eq(eq1));
    comp_1 #(.WIDTH(1), .SIGNED(1'b1)) u_w1s (.clk(clk), .rst_n(rst_n), .A(a1s), .B(b1s), .lt(lt1s), .gt(gt1s), .eq(eq1s));
    comp_1 #(.WIDTH(8), .SIGNED(1'b0)) u_w8u (.clk(clk), .rst_n(rst_n), .A(a8),  .B(b8),  .lt(lt8),  .gt(gt8),  .eq(eq8));
    comp_1 #(.WIDTH(8), .SIGNED(1'b1)) u_w8s (.clk(clk), .rst_n(rst_n), .A(a8s), .B(b8s), .lt(lt8s), .gt(gt8s), .eq(eq8s));

    typedef struct {
        logic [2:0] e1;
        logic [2:0] e1s;
        logic [2:0] e8;
        logic [2:0] e8s;
    } exp_t;

    localparam logic [2:0] EQ = 3'b001;
    exp_t rst_exp = '{e1: EQ, e1s: EQ, e8: EQ, e8s: EQ};
    exp_t sb[$];
    exp_t prev;
    int   n_chk = 0;
    int   n_fail = 0;

    // {lt, gt, eq} of two integer values
    function automatic logic [2:0] rel(int a, int b);
        return {a < b, a > b, a == b};
    endfunction

    task automatic check(string tag, logic [2:0] obs, logic [2:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed={lt,gt,eq}=%b expected=%b", tag, obs, expv);
        end
        n_chk++;
        assert ($countones(obs) == 1) else begin
            n_fail++;
            $error("FAIL %s_onehot observed=%b expected exactly one flag set", tag, obs);
        end
    endtask

    task automatic check_all(string tag, exp_t e);
        check({tag, "_w1u"}, {lt1, gt1, eq1}, e.e1);
        check({tag, "_w1s"}, {lt1s, gt1s, eq1s}, e.e1s);
        check({tag, "_w8u"}, {lt8, gt8, eq8}, e.e8);
        check({tag, "_w8s"}, {lt8s, gt8s, eq8s}, e.e8s);
    endtask

    // Applies operands between edges; outputs must hold their previous values until the next edge.
    task automatic drive(logic x1, logic y1, logic xs, logic ys,
                         logic [7:0] x8, logic [7:0] y8, logic [7:0] x8s, logic [7:0] y8s);
        a1 = x1; b1 = y1; a1s = xs; b1s = ys;
        a8 = x8; b8 = y8; a8s = x8s; b8s = y8s;
        #1 check_all("hold", prev);
        sb.push_back('{e1:  rel(int'(x1), int'(y1)),
                       e1s: rel(-int'(xs), -int'(ys)),
                       e8:  rel(int'(x8), int'(y8)),
                       e8s: rel(int'($signed(x8s)), int'($signed(y8s)))});
    endtask

    task automatic collect(string tag);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s scoreboard empty, observed no expected entry", tag);
        end else begin
            prev = sb.pop_front();
            check_all(tag, prev);
        end
    endtask

    task automatic step(string tag, logic x1, logic y1, logic xs, logic ys,
                        logic [7:0] x8, logic [7:0] y8, logic [7:0] x8s, logic [7:0] y8s);
        @(negedge clk);
        drive(x1, y1, xs, ys, x8, y8, x8s, y8s);
        collect(tag);
    endtask

    initial begin
        prev = rst_exp;
        a1 = 1'b1; b1 = 1'b0; a1s = 1'b1; b1s = 1'b0;
        a8 = 8'h01; b8 = 8'h00; a8s = 8'h01; b8s = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1 check_all("reset", rst_exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00);
        collect("release");

        step("sweep0", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        step("sweep1", 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00);
        step("sweep2", 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 8'h01, 8'h01);
        step("sweep3", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h01);
        step("sweep4", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

        step("pre_async", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_all("async_rst", rst_exp);
        prev = rst_exp;
        @(posedge clk);
        #1 check_all("async_hold", rst_exp);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00);
        collect("rerelease");

        step("ff_00", 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00);
        step("7f_80", 1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 8'h80, 8'h7F, 8'h80);
        step("a5_a5", 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
        step("80_7f", 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h7F, 8'h80, 8'h7F);
        step("00_ff", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF);

        for (int i = 0; i < 1000; i++) begin
            step("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/comp_1.md
# comp_1

Single-clock magnitude comparator that compares two operands A and B. It drives three registered, mutually exclusive flags: less-than, greater-than and equal. It is used as a leaf status block wherever downstream logic needs a glitch-free, clock-aligned relation between two values. The default configuration is a 1-bit unsigned compare; the width and signedness are parameters.

## Interface
Parameters:
- WIDTH, default 1 — operand width in bits, legal range 1..64.
- SIGNED, default 0 — 0: unsigned compare; 1: two's-complement compare.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, release is synchronised by the integrator.
- A  input  WIDTH  left operand.
- B  input  WIDTH  right operand.
- lt  output  1  registered flag, 1 when A < B.
- gt  output  1  registered flag, 1 when A > B.
- eq  output  1  registered flag, 1 when A == B.

## Operation
- Each rising clk edge samples A and B and computes the relation.
- lt/gt/eq are loaded into output registers on that same edge.
- Compare rules:
  - SIGNED=0: operands are unsigned, range 0..2^WIDTH-1.
  - SIGNED=1: the MSB is the sign bit, range -2^(WIDTH-1)..2^(WIDTH-1)-1.
  - WIDTH=1 with SIGNED=1: value 1 means -1, so 1 < 0.
- Invariant: exactly one of lt, gt, eq is 1 at all times, including during and after reset.
- Reset values: lt=0, gt=0, eq=1. This matches the result for A=B=0.
- No internal state other than the three output flops. No enable, no handshake; a new result is produced every cycle.
- X or Z on A/B is not qualified; the result in that case is don't-care, but the one-hot invariant must still hold for any 0/1 input pattern.

## Timing
- Latency: 1 clk cycle. Operands present before edge N appear on lt/gt/eq after edge N.
- Throughput: one compare per cycle; back-to-back operand changes are each reflected one cycle later.
- Outputs change only on a clk rising edge or on rst_n falling. They are glitch-free between edges.
- Reset asserted mid-operation forces lt=0, gt=0, eq=1 immediately, regardless of A/B.
- The first edge after rst_n release loads the compare of the operands present at that edge.
- Operand changes between edges have no output effect until the next edge.
- Combinational depth: one WIDTH-bit compare; must close timing at the codebase's standard clock for WIDTH ≤ 64.

## Test plan
- Reset: hold rst_n=0 with A=1, B=0 for 3 cycles -> lt=0, gt=0, eq=1 throughout. Then release rst_n -> gt=1 after the first edge.
- 1-bit sweep (WIDTH=1, SIGNED=0), sequence (A,B) = (0,0), (1,0), (1,1), (0,1), (0,0), one per cycle -> outputs one cycle later are eq, gt, eq, lt, eq.
- Async reset mid-stream: apply A=0, B=1 so lt=1, then drop rst_n between edges -> lt=0, eq=1 without waiting for a clk edge.
- Wide unsigned (WIDTH=8): A=8'hFF, B=8'h00 -> gt=1. A=8'h7F, B=8'h80 -> lt=1. A=B=8'hA5 -> eq=1.
- Signed (WIDTH=8, SIGNED=1): A=8'hFF (-1), B=8'h00 -> lt=1. A=8'h80 (-128), B=8'h7F (127) -> lt=1. A=8'h7F, B=8'h80 -> gt=1.
- Randomized: 1000 random (A,B) pairs per configuration -> each output matches a reference model delayed 1 cycle, with lt+gt+eq == 1 on every cycle.
